syn_av_mm_lb_bridge: RTL
========================

// Module: syn_av_mm_lb_bridge
// PURPOSE
//  Avalon-MM slave that terminates the TB/host MM port (av_read/av_write/av_addr/...)
//  and converts each transfer into a single-pulse local-bus (lb_*) access to
//  the synesthesia register blocks. Stretches the master with av_wait_req until
//  lb_ack or a timeout; one outstanding transfer, no pipelining.
// PARAMETERS
//  ADDR_W         16       address width, Avalon and local bus
//  DATA_W         16       data width, Avalon and local bus
//  TIMEOUT_CYC    255      cycles to wait for lb_ack after issue (>=1)
//  TIMEOUT_RDATA  'hDEAD   av_read_data returned on read timeout (truncated to DATA_W)
// PORTS
//  av_clk         in   1       single clock; all logic on rising edge
//  av_rst         in   1       asynchronous, active-low reset
//  av_read        in   1       Avalon read request, held until av_wait_req=0
//  av_write       in   1       Avalon write request, held until av_wait_req=0
//  av_begin_xfr   in   1       first-cycle marker; informational, not decoded
//  av_addr        in   ADDR_W  transfer address
//  av_write_data  in   DATA_W  write data
//  av_wait_req    out  1       1 = stall master; 0 for exactly one cycle = done
//  av_read_data   out  DATA_W  read data, valid in the av_wait_req=0 cycle of a read
//  lb_rd_en       out  1       one-cycle local read strobe
//  lb_wr_en       out  1       one-cycle local write strobe
//  lb_addr        out  ADDR_W  local address, stable from issue until done
//  lb_wdata       out  DATA_W  local write data, stable from issue until done
//  lb_rdata       in   DATA_W  local read data, sampled with lb_ack
//  lb_ack         in   1       local completion, 1 cycle; sampled from ISSUE cycle on
//  err_clr        in   1       clears sticky error flags
//  err_timeout    out  1       sticky: an access timed out
//  err_rdwr       out  1       sticky: av_read and av_write seen together
//  busy           out  1       1 in any state other than IDLE
// BEHAVIOUR
//  Reset (av_rst=0): state IDLE, av_wait_req=1, av_read_data=0, lb_rd_en=lb_wr_en=0,
//   lb_addr=lb_wdata=0, counter=0, err_*=0, busy=0. All outputs registered.
//  av_wait_req is 1 in every state except DONE (legal: slave may stall while idle).
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE : on av_read|av_write latch av_addr/av_write_data into lb_addr/lb_wdata,
//          latch op type; go ISSUE. Both high: treat as write, set err_rdwr.
//   ISSUE: lb_rd_en or lb_wr_en =1 for this cycle only; counter=0. If lb_ack this
//          cycle -> DONE, else -> WAIT.
//   WAIT : counter++ each cycle; lb_ack -> DONE (capture lb_rdata on reads);
//          counter reaching TIMEOUT_CYC without ack -> DONE with
//          av_read_data=TIMEOUT_RDATA (reads), set err_timeout.
//   DONE : av_wait_req=0 one cycle; av_read_data holds captured value; -> IDLE.
//  Latency: request seen cycle 0, ISSUE cycle 1, DONE no earlier than cycle 2;
//   ack in cycle k>=1 -> DONE in cycle k+1. Back-to-back: next request accepted in
//   IDLE the cycle after DONE (3-cycle minimum per transfer).
//  Write completion: av_read_data unchanged on writes.
//  lb_ack in IDLE or DONE (late/spurious) ignored, no flag. Request inputs ignored
//   outside IDLE (master holds them stable per Avalon).
//  err_clr and a new error in same cycle: set wins. Counter width
//   $clog2(TIMEOUT_CYC+1), saturates, never wraps.
//  Reset mid-transfer: immediate return to reset values; no strobe reissued.
// TESTING
//  1 write addr 0x0010 data 0xA5A5, lb_ack same cycle as lb_wr_en -> one lb_wr_en
//    pulse, lb_addr=0x0010, av_wait_req=0 exactly in cycle 2, no errors.
//  2 read addr 0x0020, lb_ack 5 cycles after lb_rd_en with lb_rdata=0x1234 ->
//    av_read_data=0x1234 with av_wait_req=0 in cycle 7, single lb_rd_en pulse.
//  3 read with no lb_ack, TIMEOUT_CYC=8 -> av_wait_req=0 at cycle 10,
//    av_read_data=0xDEAD, err_timeout=1 until err_clr; late lb_ack ignored.
//  4 av_read=av_write=1 -> lb_wr_en only, err_rdwr=1, err_clr -> 0.
//  5 4 back-to-back writes, ack latency 0 -> completions every 3 cycles, data order
//    preserved.
//  6 av_rst low during WAIT -> all outputs at reset values next cycle; after release
//    new read completes normally.

Source files
------------

// File: rtl/syn_av_mm_lb_bridge.sv
// Avalon-MM slave to local-bus bridge.
// Each Avalon read or write becomes one single-cycle lb_rd_en/lb_wr_en strobe.
// The master is stalled with av_wait_req until lb_ack arrives or the access times out.
// Only one transfer is outstanding at a time.
// Ports:
//   av_clk, av_rst          clock, asynchronous active-low reset
//   av_read/av_write/...    Avalon-MM slave side (av_begin_xfr is not decoded)
//   av_wait_req             low for exactly one cycle when a transfer completes
//   av_read_data            read data, valid while av_wait_req is low after a read
//   lb_*                    local-bus strobes, address, write data, read data and ack
//   err_clr, err_timeout,   sticky error flags and their clear
//   err_rdwr
//   busy                    the bridge is not idle
module syn_av_mm_lb_bridge #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned TIMEOUT_CYC   = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD
) (
  input  logic              av_clk,
  input  logic              av_rst,
  input  logic              av_read,
  input  logic              av_write,
  input  logic              av_begin_xfr,
  input  logic [ADDR_W-1:0] av_addr,
  input  logic [DATA_W-1:0] av_write_data,
  output logic              av_wait_req,
  output logic [DATA_W-1:0] av_read_data,
  output logic              lb_rd_en,
  output logic              lb_wr_en,
  output logic [ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_ack,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic              err_rdwr,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   counter_q, counter_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0] lb_wdata_q, lb_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              wait_req_q, wait_req_d;
  logic              busy_q, busy_d;
  logic              err_to_q, err_to_d;
  logic              err_rdwr_q, err_rdwr_d;

  // First-cycle marker is informational only.
  logic unused_begin_xfr;
  assign unused_begin_xfr = av_begin_xfr;

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    is_rd_d    = is_rd_q;
    lb_addr_d  = lb_addr_q;
    lb_wdata_d = lb_wdata_q;
    rdata_d    = rdata_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    // A clear in the same cycle as a new error loses: the set below overrides it.
    err_to_d   = err_to_q & ~err_clr;
    err_rdwr_d = err_rdwr_q & ~err_clr;

    case (state_q)
      StIdle: begin
        if (av_read || av_write) begin
          lb_addr_d  = av_addr;
          lb_wdata_d = av_write_data;
          // Simultaneous read and write is handled as a write.
          is_rd_d    = av_read & ~av_write;
          rd_en_d    = av_read & ~av_write;
          wr_en_d    = av_write;
          if (av_read && av_write) begin
            err_rdwr_d = 1'b1;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        counter_d = '0;
        if (lb_ack) begin
          if (is_rd_q) begin
            rdata_d = lb_rdata;
          end
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (counter_q != CntW'(TIMEOUT_CYC)) begin
          counter_d = counter_q + 1'b1;
        end
        // An ack in the cycle the count would expire still completes normally.
        if (lb_ack) begin
          if (is_rd_q) begin
            rdata_d = lb_rdata;
          end
          state_d = StDone;
        end else if (counter_q >= CntW'(TIMEOUT_CYC - 1)) begin
          if (is_rd_q) begin
            rdata_d = TIMEOUT_RDATA[DATA_W-1:0];
          end
          err_to_d = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    wait_req_d = (state_d != StDone);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge av_clk or negedge av_rst) begin
    if (!av_rst) begin
      state_q    <= StIdle;
      counter_q  <= '0;
      is_rd_q    <= 1'b0;
      lb_addr_q  <= '0;
      lb_wdata_q <= '0;
      rdata_q    <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wait_req_q <= 1'b1;
      busy_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_rdwr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      is_rd_q    <= is_rd_d;
      lb_addr_q  <= lb_addr_d;
      lb_wdata_q <= lb_wdata_d;
      rdata_q    <= rdata_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      wait_req_q <= wait_req_d;
      busy_q     <= busy_d;
      err_to_q   <= err_to_d;
      err_rdwr_q <= err_rdwr_d;
    end
  end

  assign av_wait_req  = wait_req_q;
  assign av_read_data = rdata_q;
  assign lb_rd_en     = rd_en_q;
  assign lb_wr_en     = wr_en_q;
  assign lb_addr      = lb_addr_q;
  assign lb_wdata     = lb_wdata_q;
  assign err_timeout  = err_to_q;
  assign err_rdwr     = err_rdwr_q;
  assign busy         = busy_q;

endmodule
